pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 17 +
 rtl/pipe_skid_reg_defs.sv | 14 +
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_skid_reg.sv | 107 ++++++++++
 tb/tb_pipe_skid_reg.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline stage register: slot operations and entry counting.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

  localparam int unsigned MAX_ENTRIES = 2;
  localparam int unsigned COUNT_W     = 2;

  function automatic logic [COUNT_W-1:0] f_entry_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_skid_reg_defs.sv
// Width macros shared by every pipeline stage; stage fields are packed into the payload.
`ifndef PIPE_SKID_REG_DEFS_SV
`define PIPE_SKID_REG_DEFS_SV

`define DATA_WIDTH   32
`define PC_WIDTH     32
`define INSTR_WIDTH  32
`define REGIDX_WIDTH 5
`define IFID_WIDTH   (`PC_WIDTH + `INSTR_WIDTH)
`define IDEX_WIDTH   (`PC_WIDTH + 2 * `DATA_WIDTH + `REGIDX_WIDTH)
`define EXMEM_WIDTH  (2 * `DATA_WIDTH + `REGIDX_WIDTH)
`define MEMWB_WIDTH  (`DATA_WIDTH + `REGIDX_WIDTH)

`endif

// File: rtl/pipe_slot.sv
// One storage entry of the stage register: valid bit plus payload, optionally zeroed on invalidate.
module pipe_slot
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  slot_op_e          op_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (op_i)
        SLOT_LOAD: begin
          r_valid <= 1'b1;
          r_data  <= data_i;
        end
        SLOT_CLEAR: begin
          r_valid <= 1'b0;
          if (CLEAR_ON_BUBBLE) r_data <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with optional skid entry so in_ready_o can be registered.
`ifndef PIPE_SKID_REG_DEFS_SV
`include "pipe_skid_reg_defs.sv"
`endif

module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W          = `DATA_WIDTH,
  parameter bit SKID            = 1'b1,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_in_xfer;
  logic              w_out_xfer;
  slot_op_e          w_main_op;
  slot_op_e          w_skid_op;
  logic [DATA_W-1:0] w_main_din;

  assign w_in_xfer  = in_valid_i & in_ready_o & ~flush_i;
  assign w_out_xfer = w_main_valid & out_ready_i & ~flush_i;

  // Main refills from skid first so order is preserved; otherwise it takes the new input.
  always_comb begin
    w_main_op  = SLOT_HOLD;
    w_main_din = in_data_i;
    if (flush_i) begin
      w_main_op = SLOT_CLEAR;
    end else if (w_out_xfer) begin
      if (w_skid_valid) begin
        w_main_op  = SLOT_LOAD;
        w_main_din = w_skid_data;
      end else if (w_in_xfer) begin
        w_main_op = SLOT_LOAD;
      end else begin
        w_main_op = SLOT_CLEAR;
      end
    end else if (w_in_xfer && !w_main_valid) begin
      w_main_op = SLOT_LOAD;
    end
  end

  always_comb begin
    w_skid_op = SLOT_HOLD;
    if (flush_i) begin
      w_skid_op = SLOT_CLEAR;
    end else if (w_out_xfer && w_skid_valid) begin
      w_skid_op = w_in_xfer ? SLOT_LOAD : SLOT_CLEAR;
    end else if (w_in_xfer && w_main_valid && !w_out_xfer) begin
      w_skid_op = SLOT_LOAD;
    end
  end

  pipe_slot #(
    .DATA_W         (DATA_W),
    .CLEAR_ON_BUBBLE(CLEAR_ON_BUBBLE)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .op_i   (w_main_op),
    .data_i (w_main_din),
    .valid_o(w_main_valid),
    .data_o (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_BUBBLE(CLEAR_ON_BUBBLE)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .op_i   (w_skid_op),
        .data_i (in_data_i),
        .valid_o(w_skid_valid),
        .data_o (w_skid_data)
      );
      // Ready depends only on slot state, breaking the out_ready_i timing path.
      assign in_ready_o = ~w_skid_valid;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign in_ready_o   = ~w_main_valid | out_ready_i;
    end
  endgenerate

  assign out_valid_o = w_main_valid;
  assign out_data_o  = w_main_data;
  assign count_o     = f_entry_count(w_main_valid, w_skid_valid);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg with and without the skid entry.
module tb_pipe_skid_reg;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;

  logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_count;

  logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_count;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DW), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b1)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (s_flush),
    .in_valid_i (s_in_valid),
    .in_ready_o (s_in_ready),
    .in_data_i  (s_in_data),
    .out_valid_o(s_out_valid),
    .out_ready_i(s_out_ready),
    .out_data_o (s_out_data),
    .count_o    (s_count)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID(1'b0), .CLEAR_ON_BUBBLE(1'b1)) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (n_flush),
    .in_valid_i (n_in_valid),
    .in_ready_o (n_in_ready),
    .in_data_i  (n_in_data),
    .out_valid_o(n_out_valid),
    .out_ready_i(n_out_ready),
    .out_data_o (n_out_data),
    .count_o    (n_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string tag, input logic v, input logic [1:0] c, input logic [DW-1:0] d);
    chk({tag, "_valid"}, {31'd0, s_out_valid}, {31'd0, v});
    chk({tag, "_count"}, {30'd0, s_count}, {30'd0, c});
    chk({tag, "_data"}, s_out_data, d);
    $display("[%0t] %s skid: valid=%0b count=%0d data=%0h in_ready=%0b",
             $time, tag, s_out_valid, s_count, s_out_data, s_in_ready);
  endtask

  task automatic chk_n(input string tag, input logic v, input logic [1:0] c, input logic [DW-1:0] d);
    chk({tag, "_valid"}, {31'd0, n_out_valid}, {31'd0, v});
    chk({tag, "_count"}, {30'd0, n_count}, {30'd0, c});
    chk({tag, "_data"}, n_out_data, d);
    $display("[%0t] %s noskid: valid=%0b count=%0d data=%0h in_ready=%0b",
             $time, tag, n_out_valid, n_count, n_out_data, n_in_ready);
  endtask

  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_n[$];

  initial begin
    logic s_inx, s_outx, n_inx, n_outx;

    rst_n = 1'b1;
    s_flush = 0; s_in_valid = 0; s_out_ready = 1; s_in_data = '0;
    n_flush = 0; n_in_valid = 0; n_out_ready = 1; n_in_data = '0;

    // Reset state, asserted between edges
    #2 rst_n = 1'b0;
    #1;
    chk_s("rst", 1'b0, 2'd0, 32'h0);
    chk("rst_s_in_ready", {31'd0, s_in_ready}, 32'd1);
    chk_n("rst", 1'b0, 2'd0, 32'h0);
    chk("rst_n_in_ready", {31'd0, n_in_ready}, 32'd1);
    #19 rst_n = 1'b1;
    tick();

    // Streaming 1,2,3 with downstream always ready
    s_in_valid = 1; s_out_ready = 1;
    s_in_data = 32'd1; tick(); chk_s("stream1", 1'b1, 2'd1, 32'd1);
    s_in_data = 32'd2; tick(); chk_s("stream2", 1'b1, 2'd1, 32'd2);
    s_in_data = 32'd3; tick(); chk_s("stream3", 1'b1, 2'd1, 32'd3);
    s_in_valid = 0; tick(); chk_s("stream_drain", 1'b0, 2'd0, 32'd0);

    // Stall fills main then skid
    s_out_ready = 0; s_in_valid = 1;
    s_in_data = 32'hA; tick(); chk_s("stall_a", 1'b1, 2'd1, 32'hA);
    chk("stall_a_ready", {31'd0, s_in_ready}, 32'd1);
    s_in_data = 32'hB; tick(); chk_s("stall_b", 1'b1, 2'd2, 32'hA);
    chk("stall_b_ready", {31'd0, s_in_ready}, 32'd0);
    s_in_data = 32'hD; #1;
    chk("full_ready_pre", {31'd0, s_in_ready}, 32'd0);
    tick(); chk_s("stall_hold", 1'b1, 2'd2, 32'hA);
    s_in_valid = 0; s_out_ready = 1;
    tick(); chk_s("release_b", 1'b1, 2'd1, 32'hB);
    chk("release_ready", {31'd0, s_in_ready}, 32'd1);
    tick(); chk_s("release_empty", 1'b0, 2'd0, 32'd0);

    // Flush while full, with an input offered on the same edge
    s_out_ready = 0; s_in_valid = 1;
    s_in_data = 32'h11; tick();
    s_in_data = 32'h22; tick(); chk_s("flush_pre", 1'b1, 2'd2, 32'h11);
    s_flush = 1; s_out_ready = 1; s_in_data = 32'hC;
    tick(); chk_s("flush", 1'b0, 2'd0, 32'd0);
    chk("flush_ready", {31'd0, s_in_ready}, 32'd1);
    s_flush = 0; s_in_valid = 0;
    tick(); chk_s("flush_after", 1'b0, 2'd0, 32'd0);

    // Single-entry mode: pass-through ready and replace-on-drain
    n_out_ready = 0; n_in_valid = 1; n_in_data = 32'h3;
    tick(); chk_n("ns_load", 1'b1, 2'd1, 32'h3);
    n_in_data = 32'h6; #1;
    chk("ns_stall_ready", {31'd0, n_in_ready}, 32'd0);
    tick(); chk_n("ns_stall", 1'b1, 2'd1, 32'h3);
    n_out_ready = 1; n_in_data = 32'h5; #1;
    chk("ns_pass_ready", {31'd0, n_in_ready}, 32'd1);
    tick(); chk_n("ns_replace", 1'b1, 2'd1, 32'h5);
    n_in_valid = 0;
    tick(); chk_n("ns_drain", 1'b0, 2'd0, 32'd0);

    // Reset mid-operation with two entries held
    s_out_ready = 0; s_in_valid = 1;
    s_in_data = 32'h31; tick();
    s_in_data = 32'h32; tick(); chk_s("arst_pre", 1'b1, 2'd2, 32'h31);
    rst_n = 1'b0; #1;
    chk_s("arst_now", 1'b0, 2'd0, 32'd0);
    chk("arst_ready", {31'd0, s_in_ready}, 32'd1);
    s_out_ready = 1; s_in_valid = 0;
    tick(); chk_s("arst_edge", 1'b0, 2'd0, 32'd0);
    #3 rst_n = 1'b1;
    s_in_valid = 1; s_in_data = 32'h41;
    tick(); chk_s("arst_release", 1'b1, 2'd1, 32'h41);
    s_in_valid = 0;
    tick(); chk_s("arst_drain", 1'b0, 2'd0, 32'd0);

    // Random valid/ready/flush against a queue scoreboard, both variants
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_in_valid  = ($urandom_range(3, 0) != 0);
      s_out_ready = ($urandom_range(2, 0) != 0);
      s_flush     = ($urandom_range(96, 0) == 0);
      s_in_data   = $urandom;
      n_in_valid  = ($urandom_range(3, 0) != 0);
      n_out_ready = ($urandom_range(2, 0) != 0);
      n_flush     = ($urandom_range(96, 0) == 0);
      n_in_data   = $urandom;
      #1;
      s_inx  = s_in_valid & s_in_ready & ~s_flush;
      s_outx = s_out_valid & s_out_ready & ~s_flush;
      n_inx  = n_in_valid & n_in_ready & ~n_flush;
      n_outx = n_out_valid & n_out_ready & ~n_flush;
      chk("rnd_n_ready", {31'd0, n_in_ready},
          {31'd0, (q_n.size() == 0) | n_out_ready});
      if (s_outx) begin
        if (q_s.size() == 0) chk("rnd_s_extra", {31'd0, s_out_valid}, 32'd0);
        else chk("rnd_s_order", s_out_data, q_s[0]);
      end
      if (n_outx) begin
        if (q_n.size() == 0) chk("rnd_n_extra", {31'd0, n_out_valid}, 32'd0);
        else chk("rnd_n_order", n_out_data, q_n[0]);
      end
      tick();
      if (s_flush) q_s.delete();
      else begin
        if (s_outx && q_s.size() != 0) void'(q_s.pop_front());
        if (s_inx) q_s.push_back(s_in_data);
      end
      if (n_flush) q_n.delete();
      else begin
        if (n_outx && q_n.size() != 0) void'(q_n.pop_front());
        if (n_inx) q_n.push_back(n_in_data);
      end
      chk("rnd_s_count", {30'd0, s_count}, q_s.size());
      chk("rnd_s_valid", {31'd0, s_out_valid}, {31'd0, q_s.size() != 0});
      chk("rnd_s_ready", {31'd0, s_in_ready}, {31'd0, q_s.size() < 2});
      chk("rnd_n_count", {30'd0, n_count}, q_n.size());
      chk("rnd_n_valid", {31'd0, n_out_valid}, {31'd0, q_n.size() != 0});
      if (!s_out_valid) chk("rnd_s_bubble", s_out_data, 32'd0);
      if (!n_out_valid) chk("rnd_n_bubble", n_out_data, 32'd0);
    end
    $display("[%0t] random phase done: skid depth=%0d noskid depth=%0d", $time, q_s.size(), q_n.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
